// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor (diff = a - b, LSB first, one bit per clock).
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
  ,output logic            ovf
`endif
);

  // state | meaning
  // IDLE  | waiting for start; operands captured on accept
  // RUN   | one full-subtractor step per clock, WIDTH steps
  // DONE  | single cycle, result valid, done pulse
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [CW-1:0]    cnt;
  logic             bw;
  logic             d, bw_next, last;

`ifdef SERIAL_SUB_OVF_EN
  logic             a_msb, b_msb;
`endif

  assign d       = a_sh[0] ^ b_sh[0] ^ bw;
  assign bw_next = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & bw);
  assign last    = (cnt == CW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN: begin
        busy = 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh       <= '0;
      b_sh       <= '0;
      diff       <= '0;
      cnt        <= '0;
      bw         <= 1'b0;
      borrow_out <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
      ovf        <= 1'b0;
`endif
    end else if (state_q == IDLE && start) begin
      a_sh       <= a;
      b_sh       <= b;
      diff       <= '0;
      cnt        <= '0;
      bw         <= 1'b0;
      borrow_out <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb      <= a[WIDTH-1];
      b_msb      <= b[WIDTH-1];
      ovf        <= 1'b0;
`endif
    end else if (state_q == RUN) begin
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      // result enters at the MSB so bit 0 lands at diff[0] after WIDTH shifts
      diff <= {d, diff[WIDTH-1:1]};
      bw   <= bw_next;
      cnt  <= cnt + CW'(1);
      if (last) begin
        borrow_out <= bw_next;
`ifdef SERIAL_SUB_OVF_EN
        ovf        <= (a_msb != b_msb) && (d != a_msb);
`endif
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: stimulus queues hand-computed results,
// a negedge monitor checks them (and latency) whenever done pulses.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] a_i, b_i;
  logic       busy, done, borrow_out;
  logic [7:0] diff;
`ifdef SERIAL_SUB_OVF_EN
  logic       ovf;
`endif

  serial_subtractor #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a_i),
    .b          (b_i),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out)
`ifdef SERIAL_SUB_OVF_EN
    ,.ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       bo;
    logic       ov;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("done_cycle", cyc, e.cyc);
        chk("diff", diff, e.d);
        chk("borrow_out", borrow_out, e.bo);
`ifdef SERIAL_SUB_OVF_EN
        chk("ovf", ovf, e.ov);
`endif
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic issue(input logic [7:0] av, input logic [7:0] bv,
                       input logic [7:0] ed, input logic eb, input logic eo);
    wait_idle();
    a_i   = av;
    b_i   = bv;
    start = 1'b1;
    q.push_back('{ed, eb, eo, cyc + 9});
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  initial begin
    int n;
    int pushed;
    rst_n = 1'b0;
    start = 1'b0;
    a_i   = '0;
    b_i   = '0;
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_diff", diff, 0);
    chk("rst_borrow", borrow_out, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // basic op, latency and busy duration
    issue(8'h5A, 8'h23, 8'h37, 1'b0, 1'b0);
    n = 0;
    @(negedge clk);
    while (busy && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("busy_cycles", n, 9);

    // boundaries
    issue(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);
    issue(8'hC3, 8'hC3, 8'h00, 1'b0, 1'b0);

    // start held high: back-to-back ops, one accept per idle cycle
    wait_idle();
    a_i    = 8'h10;
    b_i    = 8'h01;
    start  = 1'b1;
    pushed = 0;
    n      = 0;
    while (n < 100) begin
      if (!busy) begin
        q.push_back('{8'h0F, 1'b0, 1'b0, cyc + 9});
        pushed++;
        if (pushed == 3) begin
          @(posedge clk);
          #1 start = 1'b0;
          break;
        end
      end
      @(negedge clk);
      n++;
    end
    chk("held_start_accepts", pushed, 3);

    // operand change during RUN has no effect
    issue(8'h9C, 8'h1E, 8'h7E, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    a_i = 8'hFF;
    b_i = 8'h00;
    wait_idle();

`ifdef SERIAL_SUB_OVF_EN
    issue(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
    issue(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);
    issue(8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
`endif

    // abort mid-operation: no done, outputs cleared at once
    wait_idle();
    a_i   = 8'hF0;
    b_i   = 8'h0F;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_diff", diff, 0);
    chk("abort_borrow", borrow_out, 0);
`ifdef SERIAL_SUB_OVF_EN
    chk("abort_ovf", ovf, 0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("abort_stays_idle", busy, 0);

    // post-reset op still correct
    issue(8'h01, 8'h02, 8'hFF, 1'b1, 1'b0);
    wait_idle();
    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
